ad9643_spi_slave: RTL

Serial-port front end of the AD9643 model: decodes the AD9643 three-wire SPI protocol (CSB/SCLK/SDIO) in the `clk` domain. It drives the register file's write/address/data port and returns read data on SDIO. It sits directly upstream of the register file and is the only writer of it.

---
 rtl/ad9643_spi_pkg.sv | 26 ++
 rtl/ad9643_spi_slave_pin_sync.sv | 41 ++++
 rtl/ad9643_spi_slave.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ad9643_spi_pkg.sv
// Shared definitions for the AD9643 serial-port front end: FSM states,
// instruction word layout and byte-count encodings.
package ad9643_spi_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;

  localparam int INSTR_RW_BIT   = 15;
  localparam int INSTR_W_HI_BIT = 14;
  localparam int INSTR_W_LO_BIT = 13;

  localparam logic [1:0] W_ONE    = 2'b00;
  localparam logic [1:0] W_TWO    = 2'b01;
  localparam logic [1:0] W_THREE  = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ad9643_spi_slave_pin_sync.sv
// Brings CSB/SCLK/SDIO into the clk domain and turns SCLK transitions into
// single-cycle rise/fall pulses; SDIO is delayed to line up with the pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic csb,
  input  logic sclk,
  input  logic sdio_i,
  output logic csb_s,
  output logic sdio_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [1:0] csb_ff;
  logic [1:0] sclk_ff;
  logic [1:0] sdio_ff;
  logic       sclk_d;

  // Synchronizers keep sampling through reset so CSB is already valid on release
  always_ff @(posedge clk) begin
    csb_ff  <= {csb_ff[0], csb};
    sclk_ff <= {sclk_ff[0], sclk};
    sdio_ff <= {sdio_ff[0], sdio_i};
    sclk_d  <= sclk_ff[1];
    sdio_s  <= sdio_ff[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_rise <= sclk_ff[1] & ~sclk_d;
      sclk_fall <= ~sclk_ff[1] & sclk_d;
    end
  end

  assign csb_s = csb_ff[1];

endmodule

// File: rtl/ad9643_spi_slave.sv
// AD9643 three-wire SPI slave: decodes instruction/data phases and drives the
// register file write port, returning read data on SDIO MSB first.
module ad9643_spi_slave #(
  parameter int ADDR_W = ad9643_spi_pkg::ADDR_W,
  parameter int DATA_W = ad9643_spi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csb,
  input  logic              sclk,
  input  logic              sdio_i,
  output logic              sdio_o,
  output logic              sdio_oe,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  import ad9643_spi_pkg::*;

  localparam logic [3:0] LAST_INSTR_BIT = 4'(INSTR_W - 1);
  localparam logic [3:0] LAST_DATA_BIT  = 4'(DATA_W - 1);

  logic               csb_s;
  logic               sdio_s;
  logic               sclk_rise;
  logic               sclk_fall;
  state_t             state;
  state_t             state_nxt;
  logic [3:0]         bit_cnt;
  logic [INSTR_W-2:0] shreg;
  logic [INSTR_W-1:0] instr_nxt;
  logic [DATA_W-2:0]  rd_sh;
  logic [1:0]         bytes_left;
  logic               stream;
  logic               armed;
  logic               last_byte;

  spi_pin_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .csb       (csb),
    .sclk      (sclk),
    .sdio_i    (sdio_i),
    .csb_s     (csb_s),
    .sdio_s    (sdio_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  assign instr_nxt = {shreg, sdio_s};
  assign last_byte = !stream && (bytes_left == 2'd0);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (armed && !csb_s) state_nxt = ST_INSTR;
      ST_INSTR: if (sclk_rise && bit_cnt == LAST_INSTR_BIT)
                  state_nxt = instr_nxt[INSTR_RW_BIT] ? ST_RDATA : ST_WDATA;
      ST_WDATA,
      ST_RDATA: if (sclk_rise && bit_cnt == LAST_DATA_BIT && last_byte)
                  state_nxt = ST_DONE;
      default:  state_nxt = state;
    endcase
    // A CSB release overrides any SCLK edge seen in the same cycle
    if (csb_s && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (sclk_rise && (state == ST_INSTR || state == ST_WDATA))
      shreg <= instr_nxt[INSTR_W-2:0];
    if (sclk_fall && state == ST_RDATA)
      rd_sh <= (bit_cnt == 4'd0) ? reg_rdata[DATA_W-2:0] : {rd_sh[DATA_W-3:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      reg_write  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      sdio_o     <= 1'b0;
      bytes_left <= 2'd0;
      stream     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      if (csb_s) armed <= 1'b1;
      if (reg_write) reg_addr <= reg_addr - ADDR_W'(1);
      if (csb_s) begin
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          ST_IDLE: bit_cnt <= 4'd0;
          ST_INSTR: if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_INSTR_BIT) begin
              bit_cnt    <= 4'd0;
              reg_addr   <= instr_nxt[ADDR_W-1:0];
              bytes_left <= instr_nxt[INSTR_W_HI_BIT:INSTR_W_LO_BIT];
              stream     <= (instr_nxt[INSTR_W_HI_BIT:INSTR_W_LO_BIT] == W_STREAM);
            end
          end
          ST_WDATA: if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_DATA_BIT) begin
              bit_cnt    <= 4'd0;
              reg_wdata  <= {shreg[DATA_W-2:0], sdio_s};
              reg_write  <= 1'b1;
              bytes_left <= bytes_left - 2'd1;
            end
          end
          ST_RDATA: begin
            if (sclk_fall)
              sdio_o <= (bit_cnt == 4'd0) ? reg_rdata[DATA_W-1] : rd_sh[DATA_W-2];
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_DATA_BIT) begin
                bit_cnt    <= 4'd0;
                reg_addr   <= reg_addr - ADDR_W'(1);
                bytes_left <= bytes_left - 2'd1;
              end
            end
          end
          default: bit_cnt <= bit_cnt;
        endcase
      end
    end
  end

  // Output enable lives only inside RDATA, from its first falling edge on
  always_ff @(posedge clk) begin
    if (reset)                       sdio_oe <= 1'b0;
    else if (state_nxt != ST_RDATA)  sdio_oe <= 1'b0;
    else if (sclk_fall)              sdio_oe <= 1'b1;
  end

endmodule
